// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in (master drives), stage controls and perf counters out.
// Combinational controls with registered Mem_Err/counters; the controller never back-pressures its inputs.
interface hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic [REG_ADDR_W-1:0] ID_Rs1;
   logic [REG_ADDR_W-1:0] ID_Rs2;
   logic                  ID_Rs1_Used;
   logic                  ID_Rs2_Used;
   logic [REG_ADDR_W-1:0] EX_Rd;
   logic                  EX_M_Rd_En;
   logic                  EX_Branch_Taken;
   logic                  MEM_Req;
   logic                  MEM_Ack;
   logic                  PC_En;
   logic                  IF_ID_En;
   logic                  IF_ID_Flush;
   logic                  ID_EX_En;
   logic                  ID_EX_Bubble;
   logic                  EX_MEM_En;
   logic                  MEM_WB_Bubble;
   logic                  Mem_Err;
   logic [CNT_W-1:0]      Stall_Cnt;
   logic [CNT_W-1:0]      Flush_Cnt;

   modport master (
      output ID_Rs1, ID_Rs2, ID_Rs1_Used, ID_Rs2_Used, EX_Rd, EX_M_Rd_En,
             EX_Branch_Taken, MEM_Req, MEM_Ack,
      input  PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Bubble, EX_MEM_En,
             MEM_WB_Bubble, Mem_Err, Stall_Cnt, Flush_Cnt
   );

   modport slave (
      input  ID_Rs1, ID_Rs2, ID_Rs1_Used, ID_Rs2_Used, EX_Rd, EX_M_Rd_En,
             EX_Branch_Taken, MEM_Req, MEM_Ack,
      output PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Bubble, EX_MEM_En,
             MEM_WB_Bubble, Mem_Err, Stall_Cnt, Flush_Cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze > taken-branch squash > load-use bubble.
// Controls are same-cycle combinational; a pending data-memory access freezes every stage until ack.
module hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 255,
   parameter int CNT_W      = 16
) (
   input  logic         CLK,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);
   localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [WAIT_W-1:0]     wait_cnt, wait_cnt_nxt;
   logic                  mem_err;
   logic [CNT_W-1:0]      stall_cnt, flush_cnt;
   logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
   logic                  mem_pending, raw_match;
   logic                  freeze, branch, load_use;
   logic                  pc_en, if_id_en, if_id_flush, id_ex_en;
   logic                  id_ex_bubble, ex_mem_en, mem_wb_bubble;

   assign id_rs1      = hz.ID_Rs1;
   assign id_rs2      = hz.ID_Rs2;
   assign ex_rd       = hz.EX_Rd;
   assign mem_pending = hz.MEM_Req && !hz.MEM_Ack;

   // r0 is hardwired zero, so a load targeting it never creates a dependency
   assign raw_match = hz.EX_M_Rd_En && (ex_rd != '0) &&
                      ((hz.ID_Rs1_Used && (id_rs1 == ex_rd)) ||
                       (hz.ID_Rs2_Used && (id_rs2 == ex_rd)));

   assign freeze   = (state == ERR) ||
                     (((state == RUN) || (state == MEM_WAIT)) && mem_pending);
   assign branch   = !freeze && hz.EX_Branch_Taken;
   assign load_use = !freeze && !branch && raw_match;

   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_en      = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_en     = 1'b1;
      mem_wb_bubble = 1'b0;
      if (rst) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
      end else if (freeze) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         ex_mem_en     = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (branch) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (load_use) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         RUN: begin
            if (mem_pending) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = WAIT_ONE;
            end
         end
         MEM_WAIT: begin
            // a dropped request releases the pipeline exactly like an ack
            if (!mem_pending) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_MAX)) begin
               state_nxt = ERR;
            end else if (wait_cnt != '1) begin
               wait_cnt_nxt = wait_cnt + WAIT_ONE;
            end
         end
         ERR: begin
            state_nxt = ERR;
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (state_nxt == ERR) begin
            mem_err <= 1'b1;
         end
         if ((freeze || load_use) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (branch && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

   assign hz.PC_En         = pc_en;
   assign hz.IF_ID_En      = if_id_en;
   assign hz.IF_ID_Flush   = if_id_flush;
   assign hz.ID_EX_En      = id_ex_en;
   assign hz.ID_EX_Bubble  = id_ex_bubble;
   assign hz.EX_MEM_En     = ex_mem_en;
   assign hz.MEM_WB_Bubble = mem_wb_bubble;
   assign hz.Mem_Err       = mem_err;
   assign hz.Stall_Cnt     = stall_cnt;
   assign hz.Flush_Cnt     = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (default, TIMEOUT=4, CNT_W=3) share one stimulus bus.
// Each step queues its expected outputs, then pops and compares them against the selected instance.
module tb_hazard_ctrl;
   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       t_rst = 1'b1;
   logic [4:0] t_rs1 = '0, t_rs2 = '0, t_rd = '0;
   logic       t_u1 = 1'b0, t_u2 = 1'b0, t_ld = 1'b0, t_br = 1'b0, t_req = 1'b0, t_ack = 1'b0;

   hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) if0 ();
   hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) if1 ();
   hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(3))  if2 ();

   assign {if0.ID_Rs1, if0.ID_Rs2, if0.ID_Rs1_Used, if0.ID_Rs2_Used, if0.EX_Rd, if0.EX_M_Rd_En,
           if0.EX_Branch_Taken, if0.MEM_Req, if0.MEM_Ack} = {t_rs1, t_rs2, t_u1, t_u2, t_rd, t_ld, t_br, t_req, t_ack};
   assign {if1.ID_Rs1, if1.ID_Rs2, if1.ID_Rs1_Used, if1.ID_Rs2_Used, if1.EX_Rd, if1.EX_M_Rd_En,
           if1.EX_Branch_Taken, if1.MEM_Req, if1.MEM_Ack} = {t_rs1, t_rs2, t_u1, t_u2, t_rd, t_ld, t_br, t_req, t_ack};
   assign {if2.ID_Rs1, if2.ID_Rs2, if2.ID_Rs1_Used, if2.ID_Rs2_Used, if2.EX_Rd, if2.EX_M_Rd_En,
           if2.EX_Branch_Taken, if2.MEM_Req, if2.MEM_Ack} = {t_rs1, t_rs2, t_u1, t_u2, t_rd, t_ld, t_br, t_req, t_ack};

   hazard_ctrl #(.REG_ADDR_W(5), .TIMEOUT(255), .CNT_W(16)) u_main (.CLK(CLK), .rst(t_rst), .hz(if0));
   hazard_ctrl #(.REG_ADDR_W(5), .TIMEOUT(4),   .CNT_W(16)) u_to   (.CLK(CLK), .rst(t_rst), .hz(if1));
   hazard_ctrl #(.REG_ADDR_W(5), .TIMEOUT(255), .CNT_W(3))  u_sat  (.CLK(CLK), .rst(t_rst), .hz(if2));

   // {PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Bubble, EX_MEM_En, MEM_WB_Bubble}
   logic [6:0] ctl0, ctl1, ctl2;
   assign ctl0 = {if0.PC_En, if0.IF_ID_En, if0.IF_ID_Flush, if0.ID_EX_En, if0.ID_EX_Bubble, if0.EX_MEM_En, if0.MEM_WB_Bubble};
   assign ctl1 = {if1.PC_En, if1.IF_ID_En, if1.IF_ID_Flush, if1.ID_EX_En, if1.ID_EX_Bubble, if1.EX_MEM_En, if1.MEM_WB_Bubble};
   assign ctl2 = {if2.PC_En, if2.IF_ID_En, if2.IF_ID_Flush, if2.ID_EX_En, if2.ID_EX_Bubble, if2.EX_MEM_En, if2.MEM_WB_Bubble};

   localparam logic [6:0] C_RST  = 7'b0000000;
   localparam logic [6:0] C_NORM = 7'b1101010;
   localparam logic [6:0] C_FRZ  = 7'b0000001;
   localparam logic [6:0] C_BR   = 7'b1111110;
   localparam logic [6:0] C_LU   = 7'b0001110;

   typedef struct {
      logic       rst;
      logic [4:0] rs1; logic u1;
      logic [4:0] rs2; logic u2;
      logic [4:0] rd;  logic ld;
      logic br; logic req; logic ack;
      logic [6:0]  ctl;    // during the cycle
      logic        err;    // after the edge
      logic [15:0] stall;  // after the edge
      logic [15:0] flush;  // after the edge
   } vec_t;

   typedef struct {
      logic [6:0]  ctl;
      logic        err;
      logic [15:0] stall;
      logic [15:0] flush;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d got %h want %h", name, step_no, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input int sel);
      exp_t       e;
      logic [6:0] c;
      logic       er;
      logic [15:0] sc, fc;
      @(negedge CLK);
      t_rst = v.rst; t_rs1 = v.rs1; t_u1 = v.u1; t_rs2 = v.rs2; t_u2 = v.u2;
      t_rd = v.rd; t_ld = v.ld; t_br = v.br; t_req = v.req; t_ack = v.ack;
      sb_q.push_back('{v.ctl, v.err, v.stall, v.flush});
      #1;
      c = (sel == 0) ? ctl0 : (sel == 1) ? ctl1 : ctl2;
      @(posedge CLK);
      #1;
      case (sel)
         0:       begin er = if0.Mem_Err; sc = if0.Stall_Cnt; fc = if0.Flush_Cnt; end
         1:       begin er = if1.Mem_Err; sc = if1.Stall_Cnt; fc = if1.Flush_Cnt; end
         default: begin er = if2.Mem_Err; sc = 16'(if2.Stall_Cnt); fc = 16'(if2.Flush_Cnt); end
      endcase
      if (sb_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty step %0d got 0 want 1", step_no);
      end else begin
         e = sb_q.pop_front();
         chk("ctl",       16'(c),  16'(e.ctl));
         chk("mem_err",   16'(er), 16'(e.err));
         chk("stall_cnt", sc,      e.stall);
         chk("flush_cnt", fc,      e.flush);
      end
      step_no++;
   endtask

   vec_t tbl[$];
   vec_t v;

   initial begin
      //        rst rs1 u1 rs2 u2 rd ld br rq ak ctl  err stall flush
      tbl = '{
         '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, 0, 0},
         '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0, 0},
         '{0, 0, 0, 5, 1, 5, 1, 0, 0, 0, C_LU,   0, 1, 0},
         '{0, 0, 0, 5, 1, 5, 0, 0, 0, 0, C_NORM, 0, 1, 0},
         '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0, C_NORM, 0, 1, 0},
         '{0, 7, 0, 0, 0, 7, 1, 0, 0, 0, C_NORM, 0, 1, 0},
         '{0, 7, 1, 0, 0, 7, 1, 0, 0, 0, C_LU,   0, 2, 0},
         '{0, 7, 1, 0, 0, 7, 1, 1, 0, 0, C_BR,   0, 2, 1},
         '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORM, 0, 2, 1},
         '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  0, 3, 1},
         '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  0, 4, 1},
         '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  0, 5, 1},
         '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORM, 0, 5, 1},
         '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 5, 1},
         '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ,  0, 6, 1},
         '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ,  0, 7, 1},
         '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_BR,   0, 7, 2},
         '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 7, 2},
         '{0, 0, 0, 5, 1, 5, 1, 0, 1, 0, C_FRZ,  0, 8, 2},
         '{0, 0, 0, 5, 1, 5, 1, 0, 1, 1, C_LU,   0, 9, 2},
         '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  0, 10, 2},
         '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 10, 2},
         '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,  0, 11, 2},
         '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST,  0, 0, 0},
         '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR,   0, 0, 1}
      };
      foreach (tbl[i]) step(tbl[i], 0);

      // Timeout instance: five frozen cycles (RUN + four waits) reach ERR; ack is then ignored
      step('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0}, 1);
      for (int i = 1; i <= 5; i++)
         step('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, (i == 5), 16'(i), 0}, 1);
      step('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_FRZ, 1, 6, 0}, 1);
      step('{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_FRZ, 1, 7, 0}, 1);
      step('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 1, 8, 0}, 1);
      step('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0}, 1);
      step('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0, 0}, 1);

      // 3-bit counter instance: sustained load-use saturates at 7
      step('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0}, 2);
      for (int i = 1; i <= 10; i++)
         step('{0, 0, 0, 5, 1, 5, 1, 0, 0, 0, C_LU, 0, 16'((i > 7) ? 7 : i), 0}, 2);
      step('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 7, 0}, 2);

      if (sb_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage core. It sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC using enable, flush and bubble controls.
- Detects load-use hazards between the ID and EX stages.
- Squashes wrong-path instructions after a taken branch resolved in EX.
- Freezes the whole pipeline while the data memory has not acknowledged a request, with a timeout error.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
REG_ADDR_W, 5, register index width.
TIMEOUT, 255, maximum memory-wait cycles before error; 0 disables the timeout.
CNT_W, 16, width of the performance counters.

Ports:
CLK  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
ID_Rs1  in  REG_ADDR_W  rs1 index of the instruction in ID.
ID_Rs2  in  REG_ADDR_W  rs2 index of the instruction in ID.
ID_Rs1_Used  in  1  ID instruction reads rs1.
ID_Rs2_Used  in  1  ID instruction reads rs2.
EX_Rd  in  REG_ADDR_W  destination index of the instruction in EX.
EX_M_Rd_En  in  1  instruction in EX is a load.
EX_Branch_Taken  in  1  branch/jump in EX resolved taken.
MEM_Req  in  1  instruction in MEM accesses data memory.
MEM_Ack  in  1  data memory completes the access this cycle.
PC_En  out  1  PC update enable.
IF_ID_En  out  1  IF/ID register write enable.
IF_ID_Flush  out  1  clear IF/ID to a NOP.
ID_EX_En  out  1  ID/EX register write enable.
ID_EX_Bubble  out  1  load zeros into the ID/EX control fields.
EX_MEM_En  out  1  EX/MEM register write enable.
MEM_WB_Bubble  out  1  insert a NOP into MEM/WB.
Mem_Err  out  1  sticky memory timeout flag.
Stall_Cnt  out  CNT_W  count of stall cycles.
Flush_Cnt  out  CNT_W  count of branch-flush cycles.

Behaviour:
- States: RUN, MEM_WAIT, ERR. Registered: state, wait counter (width clog2(TIMEOUT+1), min 1), Mem_Err, Stall_Cnt, Flush_Cnt. All other outputs are combinational from state and inputs.

Reset:
- A cycle with rst=1 sets state=RUN, wait counter=0, Mem_Err=0, Stall_Cnt=0, Flush_Cnt=0.
- While rst=1, all enables are 0 and IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble are 0.
- rst asserted mid-wait or in ERR returns the block to RUN on the next edge.

Freeze condition F:
- F = (state==MEM_WAIT or RUN) and MEM_Req and !MEM_Ack, or state==ERR.
- During F: PC_En=IF_ID_En=ID_EX_En=EX_MEM_En=0, MEM_WB_Bubble=1, IF_ID_Flush=ID_EX_Bubble=0.
- F has the highest priority and masks both branch and load-use handling.

Branch condition B:
- B = !F and EX_Branch_Taken.
- Outputs: IF_ID_Flush=1, ID_EX_Bubble=1, PC_En=1 (redirect), IF_ID_En=1, ID_EX_En=1, EX_MEM_En=1.
- B overrides load-use in the same cycle, because the ID instruction is squashed.

Load-use condition L:
- L = !F and !B and EX_M_Rd_En and EX_Rd!=0 and ((ID_Rs1_Used and ID_Rs1==EX_Rd) or (ID_Rs2_Used and ID_Rs2==EX_Rd)).
- Outputs: PC_En=0, IF_ID_En=0, ID_EX_Bubble=1, ID_EX_En=1, EX_MEM_En=1.
- Exactly one bubble per hazard. The next cycle the load is in MEM and normal forwarding applies.

Default (none of F, B, L):
- All enables 1; all flush/bubble signals 0.

FSM transitions:
- RUN to MEM_WAIT when MEM_Req and !MEM_Ack; wait counter loads 1.
- RUN with MEM_Req and MEM_Ack in the same cycle stays in RUN with no stall.
- In MEM_WAIT: MEM_Ack=1 releases the pipeline in that same cycle (B/L/default rules apply) and the next state is RUN.
- In MEM_WAIT with no ack: the counter increments. If TIMEOUT!=0 and the counter==TIMEOUT with no ack, the next state is ERR.
- In MEM_WAIT, MEM_Req dropping without ack is treated as an ack (release, go to RUN).
- ERR: Mem_Err=1, permanent freeze until rst; MEM_Ack is ignored.

Deferred branch during a freeze:
- A branch taken during F is not lost. EX is held, so EX_Branch_Taken is still high on the first unfrozen cycle and B applies then.

Counters:
- Stall_Cnt increments on every non-reset cycle with F or L.
- Flush_Cnt increments on every cycle with B.
- Both counters saturate at all-ones.

Test Plan:
- Load-use: EX_M_Rd_En=1, EX_Rd=5, ID_Rs2=5, ID_Rs2_Used=1 -> for 1 cycle PC_En=0, IF_ID_En=0, ID_EX_Bubble=1; Stall_Cnt=1. Repeat with EX_Rd=0 -> no stall.
- Branch plus hazard in the same cycle: EX_Branch_Taken=1 with a load-use match -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_En=1; Flush_Cnt=1, Stall_Cnt unchanged.
- Memory wait: MEM_Req=1, MEM_Ack held 0 for 3 cycles, then 1 -> all enables 0 and MEM_WB_Bubble=1 for 3 cycles, released in the ack cycle; Stall_Cnt=3, state back to RUN.
- Branch during freeze: EX_Branch_Taken=1 held through a 2-cycle memory wait -> no flush while frozen, IF_ID_Flush=1 in the ack cycle; Flush_Cnt=1.
- Timeout: TIMEOUT=4, MEM_Req=1, no ack -> state=ERR after 4 wait cycles, Mem_Err=1 stays set with the pipeline frozen even after MEM_Ack=1. rst=1 for one cycle -> Mem_Err=0, counters=0, RUN.
- Counter saturation: CNT_W=3, 10 consecutive load-use stalls -> Stall_Cnt=7 and holds at 7.
